// File: rtl/hapara_icap_burst_arbiter_if.sv
// Bundle of requester-side and ICAP-side signals for the ICAP burst arbiter.
// The arbiter connects through the slave modport; requesters and the ICAP
// sink (or a bench) connect through the master modport.
interface hapara_icap_burst_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int LEN_WIDTH  = 16
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*LEN_WIDTH-1:0]  len;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            s_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] s_data;
  logic [NUM_REQ-1:0]            s_ready;
  logic [NUM_REQ-1:0]            done;
  logic                          busy;
  logic                          icap_en;
  logic [DATA_WIDTH/8-1:0]       icap_we;
  logic [DATA_WIDTH-1:0]         icap_addr;
  logic [DATA_WIDTH-1:0]         icap_din;

  modport slave (
    input  req, len, s_valid, s_data,
    output grant, s_ready, done, busy, icap_en, icap_we, icap_addr, icap_din
  );

  modport master (
    output req, len, s_valid, s_data,
    input  grant, s_ready, done, busy, icap_en, icap_we, icap_addr, icap_din
  );
endinterface

// File: rtl/hapara_icap_burst_arbiter.sv
// Round-robin arbiter and burst sequencer for the ICAP write port.
// One requester at a time streams a counted burst of words onto the ICAP
// en/we/addr/din port; an idle gap separates bursts so that partial
// bitstreams never interleave. Every output is a register.
module hapara_icap_burst_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  hapara_icap_burst_arbiter_if.slave   bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [DATA_WIDTH-1:0] ADDR_STEP = DATA_WIDTH'(BYTES);
  localparam logic [BYTES-1:0]      WE_ALL    = {BYTES{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [NUM_REQ-1:0]      grant_r, grant_nxt_s;
  logic [IDX_W-1:0]        gidx_r, gidx_nxt_s;
  logic [LEN_WIDTH-1:0]    cnt_r, cnt_nxt_s;
  logic [IDX_W-1:0]        rr_r, rr_nxt_s;
  logic [GAP_W-1:0]        gap_r, gap_nxt_s;
  logic [NUM_REQ-1:0]      s_ready_r, s_ready_nxt_s;
  logic [NUM_REQ-1:0]      done_r, done_nxt_s;
  logic                    busy_r, busy_nxt_s;
  logic                    en_r, en_nxt_s;
  logic [BYTES-1:0]        we_r, we_nxt_s;
  logic [DATA_WIDTH-1:0]   addr_r, addr_nxt_s;
  logic [DATA_WIDTH-1:0]   din_r, din_nxt_s;

  logic [IDX_W-1:0]        sel_s;
  logic [IDX_W-1:0]        sel_inc_s;
  logic [LEN_WIDTH-1:0]    sel_len_s;
  logic [DATA_WIDTH-1:0]   word_s;
  logic                    accept_s;

  // First requesting index at or after ptr, wrapping around the requesters.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // Winner selection, its length field, and the granted requester's word.
  always_comb begin
    sel_s     = rr_pick(bus.req, rr_r);
    sel_inc_s = (int'(sel_s) == NUM_REQ - 1) ? '0 : sel_s + IDX_W'(1);
    sel_len_s = '0;
    word_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDX_W'(k) == sel_s) begin
        sel_len_s = bus.len[k*LEN_WIDTH +: LEN_WIDTH];
      end else begin
        sel_len_s = sel_len_s;
      end
      if (IDX_W'(k) == gidx_r) begin
        word_s = bus.s_data[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        word_s = word_s;
      end
    end
    accept_s = |(bus.s_valid & s_ready_r);
  end

  // Next-state and next-output logic for the burst sequencer.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    gidx_nxt_s  = gidx_r;
    cnt_nxt_s   = cnt_r;
    rr_nxt_s    = rr_r;
    gap_nxt_s   = gap_r;
    en_nxt_s    = 1'b0;
    we_nxt_s    = '0;
    din_nxt_s   = din_r;
    // Address steps forward once per completed write.
    addr_nxt_s  = en_r ? (addr_r + ADDR_STEP) : addr_r;

    case (state_r)
      IDLE: begin
        if (|bus.req) begin
          grant_nxt_s = NUM_REQ'(1) << sel_s;
          gidx_nxt_s  = sel_s;
          cnt_nxt_s   = sel_len_s;
          rr_nxt_s    = sel_inc_s;
          addr_nxt_s  = '0;
          if (sel_len_s != '0) begin
            state_nxt_s = XFER;
          end else begin
            state_nxt_s = DONE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      XFER: begin
        if (accept_s) begin
          en_nxt_s  = 1'b1;
          we_nxt_s  = WE_ALL;
          din_nxt_s = word_s;
          cnt_nxt_s = cnt_r - LEN_WIDTH'(1);
          if (cnt_r == LEN_WIDTH'(1)) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = XFER;
          end
        end else begin
          state_nxt_s = XFER;
        end
      end
      DONE: begin
        grant_nxt_s = '0;
        gap_nxt_s   = '0;
        if (GAP_CYCLES > 0) begin
          state_nxt_s = GAP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GAP: begin
        if (int'(gap_r) >= GAP_CYCLES - 1) begin
          gap_nxt_s   = '0;
          state_nxt_s = IDLE;
        end else begin
          gap_nxt_s   = gap_r + GAP_W'(1);
          state_nxt_s = GAP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        grant_nxt_s = '0;
      end
    endcase

    // Handshake and status outputs follow the state being entered.
    s_ready_nxt_s = (state_nxt_s == XFER) ? grant_nxt_s : '0;
    done_nxt_s    = (state_nxt_s == DONE) ? grant_nxt_s : '0;
    busy_nxt_s    = (state_nxt_s != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      grant_r   <= '0;
      gidx_r    <= '0;
      cnt_r     <= '0;
      rr_r      <= '0;
      gap_r     <= '0;
      s_ready_r <= '0;
      done_r    <= '0;
      busy_r    <= 1'b0;
      en_r      <= 1'b0;
      we_r      <= '0;
      addr_r    <= '0;
      din_r     <= '0;
    end else begin
      state_r   <= state_nxt_s;
      grant_r   <= grant_nxt_s;
      gidx_r    <= gidx_nxt_s;
      cnt_r     <= cnt_nxt_s;
      rr_r      <= rr_nxt_s;
      gap_r     <= gap_nxt_s;
      s_ready_r <= s_ready_nxt_s;
      done_r    <= done_nxt_s;
      busy_r    <= busy_nxt_s;
      en_r      <= en_nxt_s;
      we_r      <= we_nxt_s;
      addr_r    <= addr_nxt_s;
      din_r     <= din_nxt_s;
    end
  end

  assign bus.grant     = grant_r;
  assign bus.s_ready   = s_ready_r;
  assign bus.done      = done_r;
  assign bus.busy      = busy_r;
  assign bus.icap_en   = en_r;
  assign bus.icap_we   = we_r;
  assign bus.icap_addr = addr_r;
  assign bus.icap_din  = din_r;

endmodule

// File: tb/tb_hapara_icap_burst_arbiter.sv
// Directed bench for hapara_icap_burst_arbiter: single burst, round-robin,
// backpressure with isolation, zero-length, req drop, and mid-burst reset.
module tb_hapara_icap_burst_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hapara_icap_burst_arbiter_if #(.DATA_WIDTH(32), .NUM_REQ(4), .LEN_WIDTH(16)) bus ();

  hapara_icap_burst_arbiter #(
    .DATA_WIDTH(32), .NUM_REQ(4), .LEN_WIDTH(16), .GAP_CYCLES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Step one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_len(input int i, input logic [15:0] v);
    bus.len[i*16 +: 16] = v;
  endtask

  task automatic set_data(input int i, input logic [31:0] v);
    bus.s_data[i*32 +: 32] = v;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_grant"},   64'(bus.grant),     64'h0);
    chk({tag, "_s_ready"}, 64'(bus.s_ready),   64'h0);
    chk({tag, "_done"},    64'(bus.done),      64'h0);
    chk({tag, "_busy"},    64'(bus.busy),      64'h0);
    chk({tag, "_en"},      64'(bus.icap_en),   64'h0);
    chk({tag, "_we"},      64'(bus.icap_we),   64'h0);
    chk({tag, "_addr"},    64'(bus.icap_addr), 64'h0);
    chk({tag, "_din"},     64'(bus.icap_din),  64'h0);
  endtask

  logic [31:0] sb_words [4] = '{32'hAA995566, 32'h20000000, 32'h30008001, 32'h0000000D};
  logic [3:0]  rr_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int          rr_idx   [5] = '{0, 1, 2, 3, 0};
  logic        bp_valid [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          k;
    logic [31:0] exp_din;

    rst         = 1'b0;
    bus.req     = '0;
    bus.len     = '0;
    bus.s_valid = '0;
    bus.s_data  = '0;
    tick();
    tick();
    chk_reset_state("rst0");
    rst = 1'b1;

    // Single burst of 4 words from requester 0.
    set_len(0, 16'd4);
    bus.req = 4'b0001;
    tick();
    chk("sb_grant",   64'(bus.grant),   64'h1);
    chk("sb_busy",    64'(bus.busy),    64'h1);
    chk("sb_s_ready", 64'(bus.s_ready), 64'h1);
    chk("sb_en_idle", 64'(bus.icap_en), 64'h0);
    bus.req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      set_data(0, sb_words[i]);
      bus.s_valid[0] = 1'b1;
      tick();
      chk("sb_en",   64'(bus.icap_en),   64'h1);
      chk("sb_we",   64'(bus.icap_we),   64'hF);
      chk("sb_din",  64'(bus.icap_din),  64'(sb_words[i]));
      chk("sb_addr", 64'(bus.icap_addr), 64'(i * 4));
      chk("sb_done", 64'(bus.done),      (i == 3) ? 64'h1 : 64'h0);
    end
    bus.s_valid = '0;
    tick();
    chk("sb_gap1_en",    64'(bus.icap_en), 64'h0);
    chk("sb_gap1_done",  64'(bus.done),    64'h0);
    chk("sb_gap1_grant", 64'(bus.grant),   64'h0);
    chk("sb_gap1_busy",  64'(bus.busy),    64'h1);
    tick();
    chk("sb_gap2_busy",  64'(bus.busy),    64'h1);
    chk("sb_gap2_en",    64'(bus.icap_en), 64'h0);
    tick();
    chk("sb_idle_busy",  64'(bus.busy),    64'h0);

    // Round-robin from reset: all request, len 2 each.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_len(i, 16'd2);
      set_data(i, 32'h10000000 + 32'(i));
    end
    bus.s_valid = 4'b1111;
    bus.req     = 4'b1111;
    tick();
    for (int b = 0; b < 5; b++) begin
      chk("rr_grant",   64'(bus.grant),   64'(rr_order[b]));
      chk("rr_s_ready", 64'(bus.s_ready), 64'(rr_order[b]));
      tick();
      chk("rr_en1",     64'(bus.icap_en), 64'h1);
      chk("rr_hold",    64'(bus.grant),   64'(rr_order[b]));
      tick();
      chk("rr_done",    64'(bus.done),    64'(rr_order[b]));
      chk("rr_din",     64'(bus.icap_din), 64'(32'h10000000 + 32'(rr_idx[b])));
      if (b == 4) bus.req = 4'b0000;
      tick();
      chk("rr_gap_grant", 64'(bus.grant), 64'h0);
      chk("rr_gap_done",  64'(bus.done),  64'h0);
      tick();
      tick();
      chk("rr_idle_busy",  64'(bus.busy),  64'h0);
      chk("rr_idle_grant", 64'(bus.grant), 64'h0);
      tick();
    end
    chk("rr_end_grant", 64'(bus.grant), 64'h0);
    bus.s_valid = '0;

    // Backpressure on requester 1; others push 0xDEADBEEF without grant.
    set_data(0, 32'hDEADBEEF);
    set_data(2, 32'hDEADBEEF);
    set_data(3, 32'hDEADBEEF);
    bus.s_valid = 4'b1101;
    set_len(1, 16'd3);
    bus.req = 4'b0010;
    tick();
    chk("bp_grant",   64'(bus.grant),   64'h2);
    chk("bp_s_ready", 64'(bus.s_ready), 64'h2);
    bus.req = 4'b0000;
    k       = 0;
    exp_din = 32'h10000000;
    for (int s = 0; s < 6; s++) begin
      bus.s_valid[1] = bp_valid[s];
      set_data(1, 32'hB0000000 + 32'(k));
      tick();
      chk("bp_en", 64'(bus.icap_en), 64'(bp_valid[s]));
      if (bp_valid[s]) begin
        exp_din = 32'hB0000000 + 32'(k);
        chk("bp_addr", 64'(bus.icap_addr), 64'(k * 4));
        k++;
      end
      chk("bp_din",      64'(bus.icap_din), 64'(exp_din));
      chk("iso_no_dead", 64'(bus.icap_din == 32'hDEADBEEF), 64'h0);
      chk("iso_s_ready", 64'(bus.s_ready), (s == 5) ? 64'h0 : 64'h2);
      chk("bp_done",     64'(bus.done),    (s == 5) ? 64'h2 : 64'h0);
    end
    bus.s_valid = '0;
    tick();
    tick();
    tick();
    chk("bp_idle_busy", 64'(bus.busy), 64'h0);

    // Zero-length burst from requester 2.
    set_len(2, 16'd0);
    bus.req = 4'b0100;
    tick();
    chk("zl_grant",   64'(bus.grant),   64'h4);
    chk("zl_done",    64'(bus.done),    64'h4);
    chk("zl_en",      64'(bus.icap_en), 64'h0);
    chk("zl_s_ready", 64'(bus.s_ready), 64'h0);
    bus.req = 4'b0000;
    tick();
    chk("zl_grant2",  64'(bus.grant),   64'h0);
    chk("zl_done2",   64'(bus.done),    64'h0);
    chk("zl_en2",     64'(bus.icap_en), 64'h0);
    tick();
    tick();
    chk("zl_idle",    64'(bus.busy),    64'h0);

    // Requester 3: len 5, req dropped and len changed after grant.
    set_len(3, 16'd5);
    bus.req        = 4'b1000;
    bus.s_valid[3] = 1'b1;
    tick();
    chk("rd_grant", 64'(bus.grant), 64'h8);
    bus.req = 4'b0000;
    set_len(3, 16'd1);
    for (int i = 0; i < 5; i++) begin
      set_data(3, 32'hC0000000 + 32'(i));
      tick();
      chk("rd_en",   64'(bus.icap_en),   64'h1);
      chk("rd_din",  64'(bus.icap_din),  64'(32'hC0000000 + 32'(i)));
      chk("rd_addr", 64'(bus.icap_addr), 64'(i * 4));
      chk("rd_done", 64'(bus.done),      (i == 4) ? 64'h8 : 64'h0);
    end
    bus.s_valid = '0;
    tick();
    chk("rd_done_off", 64'(bus.done), 64'h0);
    tick();
    tick();
    chk("rd_idle", 64'(bus.busy), 64'h0);

    // Requester 2 burst of 6, reset after word 2.
    set_len(2, 16'd6);
    bus.req        = 4'b0100;
    bus.s_valid[2] = 1'b1;
    tick();
    chk("mr_grant", 64'(bus.grant), 64'h4);
    bus.req = 4'b0000;
    set_data(2, 32'hD0000000);
    tick();
    chk("mr_w1_din", 64'(bus.icap_din), 64'hD0000000);
    set_data(2, 32'hD0000001);
    tick();
    chk("mr_w2_addr", 64'(bus.icap_addr), 64'h4);
    rst = 1'b0;
    tick();
    chk_reset_state("mr_rst");
    rst         = 1'b1;
    bus.s_valid = '0;
    tick();
    chk("mr_no_done", 64'(bus.done), 64'h0);
    chk("mr_idle",    64'(bus.busy), 64'h0);
    set_len(0, 16'd2);
    set_len(3, 16'd2);
    bus.req        = 4'b1001;
    bus.s_valid[0] = 1'b1;
    set_data(0, 32'hE0000000);
    tick();
    chk("mr_regrant", 64'(bus.grant), 64'h1);
    bus.req = 4'b0000;
    tick();
    chk("mr_re_en",   64'(bus.icap_en),   64'h1);
    chk("mr_re_addr", 64'(bus.icap_addr), 64'h0);
    chk("mr_re_din",  64'(bus.icap_din),  64'hE0000000);
    tick();
    chk("mr_re_done", 64'(bus.done), 64'h1);
    bus.s_valid = '0;
    tick();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
